mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Memory-side end of the cache refill/writeback interface. Accepts a line-granular request from the cache controller, models main-memory access latency, then streams the line word by word. Read bursts drive mem_addr_o/mem_read_data_o into the cache set's refill path. Write bursts (writeback of dirty victims) sample the cache's outgoing word and commit it to the backing word array. Sits between cache_controller/set and the backing store, replacing the ideal zero-latency memory.

Parameters:
OFFSET_WIDTH, `CACHE_B (default 4), byte-offset width of a line; WORDS = 2**(OFFSET_WIDTH-2) words per line.
LATENCY, `MEM_LATENCY (default 4), idle cycles between request acceptance and first word; 0 is legal.
MEM_ADDR_WIDTH, `MEM_ADDR_WIDTH (default 10), word-address width of the backing array (2**MEM_ADDR_WIDTH words).

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous, active-high reset
req_i  input  1  request strobe, sampled only when busy_o=0
write_i  input  1  1 = writeback burst, 0 = refill burst; sampled with req_i
addr_i  input  32  any byte address within the target line; offset bits ignored
write_data_i  input  32  cache word corresponding to current mem_addr_o (write bursts)
busy_o  output  1  high from the cycle after acceptance through the DONE cycle
mem_addr_o  output  32  byte address of current burst word
mem_read_data_o  output  32  backing-array word at mem_addr_o during read XFER, else 0
word_valid_o  output  1  high for each XFER cycle (one word per cycle)
done_o  output  1  single-cycle pulse after last word

Behaviour:
- Reset: state IDLE, busy_o=0, word_valid_o=0, done_o=0, mem_addr_o=0, mem_read_data_o=0, counters=0. Backing array contents are NOT reset. Reset mid-burst aborts immediately with no further array writes. A partially written line stays partially written.
- FSM states:
  - IDLE: on req_i=1, latch base = {addr_i[31:OFFSET_WIDTH], OFFSET_WIDTH'b0} and write_i. Go to WAIT with lat_cnt=LATENCY-1, or straight to XFER if LATENCY=0.
  - WAIT: decrement lat_cnt; at 0 go to XFER with idx=0.
  - XFER: mem_addr_o = base + 4*idx, word_valid_o=1.
    - Read: mem_read_data_o = array[mem_addr_o[MEM_ADDR_WIDTH+1:2]], combinational read.
    - Write: array[that index] <= write_data_i at the clock edge.
    - idx increments each cycle. After idx=WORDS-1, go to DONE.
  - DONE: done_o=1, busy_o=1; next state IDLE.
- Timing: request accepted at edge ending cycle 0.
  - busy_o=1 in cycles 1..LATENCY+WORDS+1.
  - Words occupy cycles LATENCY+1..LATENCY+WORDS.
  - done_o is high in cycle LATENCY+WORDS+1.
  - Next request is accepted no earlier than cycle LATENCY+WORDS+2.
- req_i while busy_o=1 is ignored, not queued. The controller holds req_i until it sees busy_o.
- Outside XFER: mem_addr_o holds its last value, mem_read_data_o=0, word_valid_o=0.
- Address wrap: array index is mem_addr_o[MEM_ADDR_WIDTH+1:2]; upper bits alias silently. The burst never crosses a line (idx wraps within WORDS, base aligned).
- Read-after-write: a refill following a writeback to the same line returns the written data.
- Simultaneous rst_i and req_i: reset wins; request dropped.

Decomposition:
- New shared header mem.svh: `MEM_LATENCY, `MEM_ADDR_WIDTH, and typedef enum mem_state_t {IDLE, WAIT, XFER, DONE}.
- `CACHE_B stays in cache.svh.
- One sub-module, mem_array: single-port word RAM, async read, sync write (we_i, addr_i, wdata_i, rdata_o), optional $readmemh init. The FSM and counters stay in mem_responder.

Test Plan:
- Refill, LATENCY=4, WORDS=4, array preloaded with word i = 0xA000_0000+i, req addr 0x0000_0014 -> base 0x10. word_valid_o in cycles 5-8 with addresses 0x10,0x14,0x18,0x1C and data 0xA000_0004..0xA000_0007. done_o in cycle 9; busy_o low in cycle 10.
- Writeback to 0x40 with write_data_i = 0xDEAD_0000+idx, then refill of 0x40 -> read burst returns 0xDEAD_0000..0xDEAD_0003.
- LATENCY=0 refill -> first word_valid_o in cycle 1; done_o in cycle 5.
- req_i asserted during XFER of an ongoing burst -> ignored. Exactly WORDS words and one done_o pulse; no second burst until req_i is reasserted after busy_o falls.
- rst_i asserted during the second word of a writeback to 0x80 -> only word 0 updated in the array; next cycle busy_o=0, word_valid_o=0. A new refill of 0x80 returns the new word 0 plus old words 1-3.
- Address 0xFFFF_F000 with MEM_ADDR_WIDTH=10 -> accesses array index 0x000..0x003 (aliasing). mem_addr_o still shows the full 0xFFFF_F000..0xFFFF_F00C.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: default geometry, latency,
// the burst FSM state encoding and a small width helper.
package mem_responder_pkg;

  // Default byte-offset width of a cache line (16-byte lines, 4 words).
  localparam int DEF_CACHE_B        = 4;
  // Default number of idle cycles between request acceptance and first word.
  localparam int DEF_MEM_LATENCY    = 4;
  // Default word-address width of the backing array.
  localparam int DEF_MEM_ADDR_WIDTH = 10;

  // Burst sequencing states; the encoding is visible on dbg_state_o.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Single-port backing word RAM: asynchronous read, synchronous write.
// Contents are never reset; whatever was last written stays.
module mem_array #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  // Commit one word per enabled clock edge.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Combinational read of the currently addressed word.
  always_comb begin
    rdata_o = mem_q[addr_i];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory side of the cache refill/writeback interface. A line request is
// accepted in IDLE, LATENCY idle cycles model main-memory access time, then
// the line streams one word per cycle (reads out of the array for refills,
// writes into the array for writebacks), followed by a one-cycle DONE.
//
// Handshake: req_i is sampled only while busy_o is low; the request is taken
// at the clock edge where state is IDLE and req_i is high. busy_o rises the
// next cycle and stays high through the DONE cycle; requests seen while busy
// are dropped, not queued. word_valid_o marks each transferred word, done_o
// pulses once after the last word.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int OFFSET_WIDTH   = DEF_CACHE_B,
  parameter int LATENCY        = DEF_MEM_LATENCY,
  parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic        busy_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_read_data_o,
  output logic        word_valid_o,
  output logic        done_o,
  output logic [1:0]  dbg_state_o
);

  localparam int WORDS = 2 ** (OFFSET_WIDTH - 2);
  localparam int IDX_W = clog2_min1(WORDS);
  localparam int LAT_W = clog2_min1(LATENCY + 1);
  localparam logic [31:0] OFF_MASK = 32'((64'd1 << OFFSET_WIDTH) - 64'd1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  mem_state_t              state_q, state_d;
  logic [LAT_W-1:0]        lat_cnt_q, lat_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [31:0]             base_q, base_d;
  logic                    write_q, write_d;
  logic [31:0]             last_addr_q, last_addr_d;

  logic [31:0]             cur_addr;
  logic                    arr_we;
  logic [MEM_ADDR_WIDTH-1:0] arr_addr;
  logic [31:0]             arr_rdata;

  // Byte address of the word being transferred; base is line aligned so the
  // burst can never leave the line.
  always_comb begin
    cur_addr = base_q + (32'(idx_q) << 2);
    arr_addr = cur_addr[MEM_ADDR_WIDTH+1:2];
  end

  // State register and counters; reset aborts any burst immediately.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      idx_q       <= '0;
      base_q      <= '0;
      write_q     <= 1'b0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      write_q     <= write_d;
      last_addr_q <= last_addr_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    idx_d       = idx_q;
    base_d      = base_q;
    write_d     = write_q;
    last_addr_d = last_addr_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          base_d  = addr_i & ~OFF_MASK;
          write_d = write_i;
          idx_d   = '0;
          if (LATENCY == 0) begin
            state_d = XFER;
          end else begin
            state_d   = WAIT;
            lat_cnt_d = LAT_LOAD;
          end
        end
      end
      WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d = XFER;
          idx_d   = '0;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      XFER: begin
        // Remember the address so mem_addr_o holds it once the burst ends.
        last_addr_d = cur_addr;
        idx_d       = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          idx_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    busy_o          = (state_q != IDLE);
    word_valid_o    = (state_q == XFER);
    done_o          = (state_q == DONE);
    mem_addr_o      = (state_q == XFER) ? cur_addr : last_addr_q;
    mem_read_data_o = ((state_q == XFER) && !write_q) ? arr_rdata : 32'd0;
    // A reset landing on a write word must not commit that word.
    arr_we          = (state_q == XFER) && write_q && !rst_i;
    dbg_state_o     = state_q;
  end

  mem_array #(
    .AW (MEM_ADDR_WIDTH),
    .DW (32)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (arr_we),
    .addr_i  (arr_addr),
    .wdata_i (write_data_i),
    .rdata_o (arr_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance at the default latency and one with
// zero latency, both checked cycle by cycle against a word-array model and
// the request/busy/word/done timeline derived from the latency and line size.
module tb_mem_responder;

  localparam int WORDS = 4;
  localparam int LAT_A = 4;
  localparam int LAT_B = 0;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, req_a, req_b;
  logic        write_i;
  logic [31:0] addr_i, write_data_i;
  logic        busy_a, valid_a, done_a, busy_b, valid_b, done_b;
  logic [31:0] maddr_a, rdata_a, maddr_b, rdata_b;
  logic [1:0]  dbg_a, dbg_b;

  mem_responder #(.OFFSET_WIDTH(4), .LATENCY(LAT_A), .MEM_ADDR_WIDTH(AW)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .req_i(req_a), .write_i(write_i),
    .addr_i(addr_i), .write_data_i(write_data_i), .busy_o(busy_a),
    .mem_addr_o(maddr_a), .mem_read_data_o(rdata_a), .word_valid_o(valid_a),
    .done_o(done_a), .dbg_state_o(dbg_a)
  );

  mem_responder #(.OFFSET_WIDTH(4), .LATENCY(LAT_B), .MEM_ADDR_WIDTH(AW)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .req_i(req_b), .write_i(write_i),
    .addr_i(addr_i), .write_data_i(write_data_i), .busy_o(busy_b),
    .mem_addr_o(maddr_b), .mem_read_data_o(rdata_b), .word_valid_o(valid_b),
    .done_o(done_b), .dbg_state_o(dbg_b)
  );

  // Reference: backing words per instance, whether each word is known,
  // and the last burst address each instance presented.
  logic [31:0] model [2][DEPTH];
  bit          known [2][DEPTH];
  logic [31:0] prev_addr [2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int sel, input logic v);
    if (sel == 0) req_a = v; else req_b = v;
  endtask

  task automatic set_rst(input int sel, input logic v);
    if (sel == 0) rst_a = v; else rst_b = v;
  endtask

  task automatic sample(input int sel, output logic busy, output logic valid,
                        output logic done, output logic [31:0] a, output logic [31:0] d);
    if (sel == 0) begin
      busy = busy_a; valid = valid_a; done = done_a; a = maddr_a; d = rdata_a;
    end else begin
      busy = busy_b; valid = valid_b; done = done_b; a = maddr_b; d = rdata_b;
    end
  endtask

  task automatic check_quiet(input int sel, input string tag, input logic [31:0] exp_addr);
    logic busy, valid, done;
    logic [31:0] a, d;
    sample(sel, busy, valid, done, a, d);
    check_eq($sformatf("%s dut%0d busy", tag, sel), 32'(busy), 32'd0);
    check_eq($sformatf("%s dut%0d valid", tag, sel), 32'(valid), 32'd0);
    check_eq($sformatf("%s dut%0d done", tag, sel), 32'(done), 32'd0);
    check_eq($sformatf("%s dut%0d addr", tag, sel), a, exp_addr);
    check_eq($sformatf("%s dut%0d rdata", tag, sel), d, 32'd0);
  endtask

  // One complete request. Write data is wbase+word or random. abort_at >= 0
  // pulses reset during that word; poke re-raises req during the transfer.
  task automatic burst(input int sel, input bit wr, input logic [31:0] addr,
                       input bit rand_data, input logic [31:0] wbase,
                       input int abort_at, input bit poke);
    int          lat, last, widx, mi;
    bit          in_xfer;
    logic [31:0] base, exp_addr, wdata;
    logic        busy, valid, done;
    logic [31:0] a, d;
    lat  = (sel == 0) ? LAT_A : LAT_B;
    last = lat + WORDS + 1;
    base = addr & 32'hFFFF_FFF0;
    @(negedge clk);
    set_req(sel, 1'b1);
    write_i = wr;
    addr_i  = addr;
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      if (c == 1) set_req(sel, 1'b0);
      widx    = c - lat - 1;
      in_xfer = (c >= lat + 1) && (c <= lat + WORDS);
      exp_addr = in_xfer ? base + 32'(4 * widx) : prev_addr[sel];
      sample(sel, busy, valid, done, a, d);
      check_eq($sformatf("dut%0d @%h c%0d busy", sel, addr, c), 32'(busy), 32'(c <= last));
      check_eq($sformatf("dut%0d @%h c%0d valid", sel, addr, c), 32'(valid), 32'(in_xfer));
      check_eq($sformatf("dut%0d @%h c%0d done", sel, addr, c), 32'(done), 32'(c == last));
      check_eq($sformatf("dut%0d @%h c%0d addr", sel, addr, c), a, exp_addr);
      mi = int'(exp_addr[AW+1:2]);
      if (in_xfer && !wr && known[sel][mi])
        check_eq($sformatf("dut%0d @%h c%0d rdata", sel, addr, c), d, model[sel][mi]);
      else if (!in_xfer || wr)
        check_eq($sformatf("dut%0d @%h c%0d rdata", sel, addr, c), d, 32'd0);
      if (in_xfer) begin
        prev_addr[sel] = exp_addr;
        if (wr) begin
          wdata = rand_data ? $urandom : wbase + 32'(widx);
          write_data_i = wdata;
          if (widx != abort_at) begin
            model[sel][mi] = wdata;
            known[sel][mi] = 1'b1;
          end
        end
        if (widx == abort_at) begin
          set_rst(sel, 1'b1);
          @(negedge clk);
          set_rst(sel, 1'b0);
          prev_addr[sel] = 32'd0;
          check_quiet(sel, "after abort", 32'd0);
          return;
        end
        if (poke && widx == 1) set_req(sel, 1'b1);
        if (poke && widx == WORDS - 1) set_req(sel, 1'b0);
      end
    end
    if (poke) begin
      @(negedge clk);
      check_quiet(sel, "after poke", prev_addr[sel]);
    end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; req_a = 1'b0; req_b = 1'b0;
    write_i = 1'b0; addr_i = '0; write_data_i = '0;
    prev_addr[0] = '0; prev_addr[1] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      known[0][i] = 1'b0; known[1][i] = 1'b0;
      model[0][i] = '0;   model[1][i] = '0;
    end
    repeat (3) @(negedge clk);
    check_quiet(0, "in reset", 32'd0);
    check_quiet(1, "in reset", 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check_quiet(0, "post reset", 32'd0);
    check_eq("post reset dbg_a", 32'(dbg_a), 32'd0);

    // Preload: word i = A000_0000 + i across the whole array.
    for (int l = 0; l < DEPTH / WORDS; l++)
      burst(0, 1'b1, 32'(l * 16), 1'b0, 32'hA000_0000 + 32'(l * 4), -1, 1'b0);

    // Refill from an unaligned address inside line 0x10.
    burst(0, 1'b0, 32'h0000_0014, 1'b0, '0, -1, 1'b0);

    // Writeback then refill of the same line.
    burst(0, 1'b1, 32'h0000_0040, 1'b0, 32'hDEAD_0000, -1, 1'b0);
    burst(0, 1'b0, 32'h0000_0040, 1'b0, '0, -1, 1'b0);

    // Zero-latency instance: write a line, read it back.
    burst(1, 1'b1, 32'h0000_0028, 1'b1, '0, -1, 1'b0);
    burst(1, 1'b0, 32'h0000_0020, 1'b0, '0, -1, 1'b0);

    // Request raised during the transfer must be ignored.
    burst(0, 1'b0, 32'h0000_0100, 1'b0, '0, -1, 1'b1);

    // Reset during word 1 of a writeback, then read the partial line.
    burst(0, 1'b1, 32'h0000_0080, 1'b1, '0, 1, 1'b0);
    burst(0, 1'b0, 32'h0000_0080, 1'b0, '0, -1, 1'b0);

    // High address aliases onto array words 0..3.
    burst(0, 1'b0, 32'hFFFF_F000, 1'b0, '0, -1, 1'b0);
    burst(0, 1'b1, 32'hFFFF_F004, 1'b1, '0, -1, 1'b0);
    burst(0, 1'b0, 32'h0000_0000, 1'b0, '0, -1, 1'b0);

    // Reset and request in the same cycle: the request is dropped.
    @(negedge clk);
    rst_a = 1'b1; req_a = 1'b1; write_i = 1'b0; addr_i = 32'h0000_0040;
    @(negedge clk);
    rst_a = 1'b0; req_a = 1'b0;
    prev_addr[0] = 32'd0;
    check_quiet(0, "rst+req", 32'd0);
    @(negedge clk);
    check_quiet(0, "rst+req next", 32'd0);

    // Randomized traffic on both instances.
    for (int n = 0; n < 60; n++) begin
      int sel;
      sel = (n % 3 == 0) ? 1 : 0;
      burst(sel, 1'($urandom_range(0, 1)), $urandom, 1'b1, '0, -1,
            1'($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    check_eq("end dbg_a", 32'(dbg_a), 32'd0);
    check_eq("end dbg_b", 32'(dbg_b), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
